reg_op_sequencer: RTL
=====================

# reg_op_sequencer

- Control block that sequences a bank of `RegisterManager` channels (cond, src1, src0, dst) through their `reg_op` phases.
- Grants the shared memory bus to one channel at a time through per-channel `disp_online`.
- Handles `rw_halt` retries and bus timeouts.
- Sits between the instruction decoder/ALU control and the register managers; replaces the ad-hoc per-channel op driving.

## Interface
- `N_CH`, default 4: number of register channels; channel 0 has highest priority.
- `TIMEOUT`, default 255: maximum cycles any single op may wait for `ch_done`.
- `RETRY_MAX`, default 7: maximum `rw_halt` restarts per op.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous reset, active-low.
- `start` in 1: begin a sequence; sampled only in IDLE.
- `phase` in 1: 0 = operand fetch, 1 = writeback; sampled with `start`.
- `ch_en` in N_CH: channel participates in this instruction.
- `ch_ptr` in N_CH: channel is a pointer operand (`isRegPtr`).
- `ch_save` in N_CH: channel result is written back (`isNeedSave & isSaveAllowed`).
- `ch_postmod` in N_CH: pointer post-inc/dec is written back (`^regFlags`).
- `ch_done` in N_CH: `next_state` from each manager; a 'z' level counts as 0.
- `rw_halt` in 1: shared bus retry request.
- `reg_op` out N_CH*`SIZE_REG_OP`: per-channel op code; channel i occupies slice i.
- `disp_online` out N_CH: one-hot bus grant, or all-zero.
- `busy` out 1: high from the cycle after an accepted `start` until `done` or `err`.
- `done` out 1: one-cycle pulse when the sequence completes.
- `err` out 1: sticky; cleared only by reset or the next accepted `start`.
- `err_ch` out 2: index of the failing channel.

## Operation
- States: IDLE, PRE, RD, RDP, CATCH, WPREP, WR, WRP, GAP, DONE, ERR.
- **IDLE.** All `reg_op` = `REG_OP_NONE`. `start`=1 latches `phase`, `ch_en`, `ch_ptr`, `ch_save`, `ch_postmod`. Go to PRE if `phase`=0, else to CATCH.
- **Fetch (`phase`=0):**
  - PRE drives `REG_OP_PREEXECUTE` on all enabled channels together, until every enabled `ch_done` has been seen. Each `ch_done` is held in a per-channel seen-mask.
  - Then each enabled channel in ascending index order:
    - RD: `REG_OP_READ`, `disp_online` bit set, until that channel's `ch_done`.
    - If `ch_ptr`: RDP: `REG_OP_READ_P` with the same rule.
  - After the last channel, go to DONE.
- **Writeback (`phase`=1):**
  - CATCH drives `REG_OP_CATCH_DATA` on all enabled channels until all are seen.
  - WPREP drives `REG_OP_WRITE_PREP` the same way.
  - Then each channel with `ch_save` in index order:
    - WR: `REG_OP_WRITE` with grant.
    - If `ch_ptr & ch_postmod`: WRP: `REG_OP_WRITE_P` with grant.
  - Then DONE.
- **Channel skipping:** disabled or non-saving channels are skipped with zero cycles spent; they are picked by a priority encoder over the remaining mask.
- **Retry:**
  - Trigger: `rw_halt`=1 in RD or RDP while the active channel's `ch_done`=0.
  - Go to GAP for 1 cycle: active channel `reg_op` = `REG_OP_NONE`, `disp_online`=0. This re-arms the manager's `single`.
  - Then re-enter the same state; the retry counter increments.
- **Errors:**
  - Retry counter exceeding `RETRY_MAX` → ERR.
  - Wait counter reaching `TIMEOUT` in any op → ERR.
  - The wait counter and retry counter clear on every op advance.
- **ERR:** all outputs idle, `err`=1, `err_ch` = active channel. Return to IDLE on the next cycle; `err` stays asserted.
- **No enabled channels:** a fetch with `ch_en`=0 runs PRE for 1 cycle and then DONE.
- **`start` while busy:** ignored.

## Timing
- **Reset values:** every output 0, `reg_op` = `REG_OP_NONE`, state IDLE. A reset mid-sequence drops the grant on the same edge.
- **Start to first op:** `start` in cycle T → first op visible at T+1.
- **Op advance:** `ch_done` sampled high in cycle T → the next op (or next channel) is driven at T+1.
  - Minimum 1 cycle per op.
  - No gap cycle between channels.
- **Grant rules:**
  - `disp_online` changes only on state transitions.
  - Never more than one bit set.
  - Zero in PRE, CATCH, WPREP and GAP.
- **Completion:** DONE lasts 1 cycle with `done`=1; `busy` falls in the same cycle.
- **Counter width:** the wait counter is wide enough for `TIMEOUT` and saturates there.

## Structure
- Op codes (`REG_OP_*`, including a new `REG_OP_NONE` distinct from all existing codes) and `SIZE_REG_OP` stay in `misc_codes.v`.
- Sequencer state encodings are added to `states.v` as `SEQ_*` defines.
- One sub-module, `ch_prio_enc`: a combinational priority encoder that returns the lowest pending channel index plus a valid flag.
- The FSM, counters and masks live in the top module.

## Test plan
- **Fetch, all channels:** `ch_en`=4'b1111, `ch_ptr`=4'b0100, each manager answers `ch_done` 2 cycles after its op → PRE, RD0, RD1, RD2, RDP2, RD3; `done` at the cycle after RD3 completes; grant one-hot throughout.
- **Writeback with pointer:** `phase`=1, `ch_en`=4'b1001, `ch_save`=4'b1000, `ch_ptr`=4'b1000, `ch_postmod`=4'b1000 → CATCH, WPREP, WR3, WRP3, DONE; channel 0 never granted.
- **Retry:** `rw_halt` pulsed once during RD1 → exactly 1 GAP cycle with ch1 op `REG_OP_NONE`, READ reissued, sequence completes with `err`=0.
- **Retry overflow:** `rw_halt` held high in RD2 → `err`=1, `err_ch`=2 after 8 GAP cycles; all grants 0; IDLE.
- **Timeout:** `TIMEOUT`=16, `ch_done` never asserted in WR0 → `err`=1, `err_ch`=0 at cycle 16 of WR0.
- **Reset mid-operation:** `rst`=0 during RD1 → next edge: `reg_op` all `REG_OP_NONE`, `disp_online`=0, `busy`=0; a new `start` then runs normally.

Source files
------------

// File: rtl/reg_op_sequencer_pkg.sv
// reg_op_sequencer_pkg: register-manager op codes, sequencer states and state lookup helpers
package reg_op_sequencer_pkg;
  localparam int SIZE_REG_OP = 4;
  typedef enum logic [SIZE_REG_OP-1:0] {
    REG_OP_NONE       = 4'd0,
    REG_OP_PREEXECUTE = 4'd1,
    REG_OP_READ       = 4'd2,
    REG_OP_READ_P     = 4'd3,
    REG_OP_CATCH_DATA = 4'd4,
    REG_OP_WRITE_PREP = 4'd5,
    REG_OP_WRITE      = 4'd6,
    REG_OP_WRITE_P    = 4'd7
  } reg_op_e;
  typedef enum logic [3:0] {
    SEQ_IDLE, SEQ_PRE, SEQ_RD, SEQ_RDP, SEQ_CATCH, SEQ_WPREP,
    SEQ_WR, SEQ_WRP, SEQ_GAP, SEQ_DONE, SEQ_ERR
  } seq_state_e;
  function automatic reg_op_e op_of(seq_state_e s);
    case (s)
      SEQ_PRE:   return REG_OP_PREEXECUTE;
      SEQ_RD:    return REG_OP_READ;
      SEQ_RDP:   return REG_OP_READ_P;
      SEQ_CATCH: return REG_OP_CATCH_DATA;
      SEQ_WPREP: return REG_OP_WRITE_PREP;
      SEQ_WR:    return REG_OP_WRITE;
      SEQ_WRP:   return REG_OP_WRITE_P;
      default:   return REG_OP_NONE;
    endcase
  endfunction
  function automatic logic is_group(seq_state_e s);
    return s inside {SEQ_PRE, SEQ_CATCH, SEQ_WPREP};
  endfunction
  function automatic logic is_grant(seq_state_e s);
    return s inside {SEQ_RD, SEQ_RDP, SEQ_WR, SEQ_WRP};
  endfunction
endpackage

// File: rtl/reg_op_sequencer_ch_prio_enc.sv
// ch_prio_enc: lowest pending channel index plus valid flag
module ch_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         vld
);
  // scan from the top so the lowest set bit wins
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = req[i] ? W'(i) : idx;
  end
  assign vld = |req;
endmodule

// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer: walks register-manager channels through their reg_op phases with a one-hot bus grant
module reg_op_sequencer
  import reg_op_sequencer_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int TIMEOUT   = 255,
  parameter int RETRY_MAX = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        phase,
  input  logic [N_CH-1:0]             ch_en,
  input  logic [N_CH-1:0]             ch_ptr,
  input  logic [N_CH-1:0]             ch_save,
  input  logic [N_CH-1:0]             ch_postmod,
  input  logic [N_CH-1:0]             ch_done,
  input  logic                        rw_halt,
  output logic [N_CH*SIZE_REG_OP-1:0] reg_op,
  output logic [N_CH-1:0]             disp_online,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [1:0]                  err_ch
);
  localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(RETRY_MAX + 2);
  seq_state_e st, n_st, ret, n_ret, walk, tgt;
  logic [CW-1:0] ch, n_ch, nidx;
  logic [N_CH-1:0] en, ptr, pmod, pend, seen, n_en, n_pend, n_seen, sel, oh, n_disp;
  logic [N_CH*SIZE_REG_OP-1:0] n_reg_op;
  logic [TW-1:0] wcnt, n_wcnt;
  logic [RW-1:0] rcnt, n_rcnt;
  logic nvld, all_seen, cd, acc, adv, stay;
  assign acc = st == SEQ_IDLE && start;
  assign n_en = acc ? ch_en : en;
  assign oh = N_CH'(1) << ch;
  assign sel = is_group(st) ? pend : pend & ~oh;
  assign all_seen = ((seen | ch_done) & en) == en;
  assign cd = ch_done[ch];
  assign adv = (is_group(st) && all_seen) || (is_grant(st) && cd);
  assign walk = nvld ? (st inside {SEQ_PRE, SEQ_RD, SEQ_RDP} ? SEQ_RD : SEQ_WR) : SEQ_DONE;
  assign stay = st == SEQ_CATCH || (st == SEQ_RD && ptr[ch]) || (st == SEQ_WR && ptr[ch] && pmod[ch]);
  assign tgt = st == SEQ_CATCH ? SEQ_WPREP : st == SEQ_RD && stay ? SEQ_RDP : st == SEQ_WR && stay ? SEQ_WRP : walk;
  ch_prio_enc #(.N(N_CH), .W(CW)) u_enc (
    .req(sel),
    .idx(nidx),
    .vld(nvld)
  );
  // next state, channel pointer, masks and counters, plus the outputs the next state will drive
  always_comb begin
    n_st = st;
    n_ch = ch;
    n_pend = pend;
    n_ret = ret;
    n_seen = is_group(st) ? seen | ch_done : seen;
    n_wcnt = wcnt == TW'(TIMEOUT) ? wcnt : wcnt + TW'(1);
    n_rcnt = rcnt;
    if (acc) begin
      n_st = phase ? SEQ_CATCH : SEQ_PRE;
      n_pend = phase ? ch_save & ch_en : ch_en;
      n_ch = '0;
      n_seen = '0;
      n_wcnt = '0;
      n_rcnt = '0;
    end else if (st == SEQ_GAP) begin
      n_st = rcnt == RW'(RETRY_MAX) ? SEQ_ERR : ret;
      n_rcnt = rcnt + RW'(1);
      n_wcnt = '0;
    end else if (st inside {SEQ_DONE, SEQ_ERR}) begin
      n_st = SEQ_IDLE;
    end else if (adv) begin
      n_st = tgt;
      n_ch = stay ? ch : nidx;
      n_pend = stay ? pend : sel;
      n_seen = '0;
      n_wcnt = '0;
      n_rcnt = '0;
    end else if (st inside {SEQ_RD, SEQ_RDP} && rw_halt) begin
      n_st = SEQ_GAP;
      n_ret = st;
      n_wcnt = '0;
    end else if ((is_group(st) || is_grant(st)) && wcnt == TW'(TIMEOUT - 1)) begin
      n_st = SEQ_ERR;
    end
    n_reg_op = '0;
    for (int i = 0; i < N_CH; i++)
      n_reg_op[i*SIZE_REG_OP +: SIZE_REG_OP] = (is_group(n_st) && n_en[i]) || (is_grant(n_st) && n_ch == CW'(i)) ? op_of(n_st) : REG_OP_NONE;
    n_disp = is_grant(n_st) ? N_CH'(1) << n_ch : '0;
  end
  // state, latched instruction context and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      st <= SEQ_IDLE;
      ret <= SEQ_IDLE;
      ch <= '0;
      en <= '0;
      ptr <= '0;
      pmod <= '0;
      pend <= '0;
      seen <= '0;
      wcnt <= '0;
      rcnt <= '0;
      reg_op <= '0;
      disp_online <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      err_ch <= '0;
    end else begin
      st <= n_st;
      ret <= n_ret;
      ch <= n_ch;
      en <= n_en;
      ptr <= acc ? ch_ptr : ptr;
      pmod <= acc ? ch_postmod : pmod;
      pend <= n_pend;
      seen <= n_seen;
      wcnt <= n_wcnt;
      rcnt <= n_rcnt;
      reg_op <= n_reg_op;
      disp_online <= n_disp;
      busy <= !(n_st inside {SEQ_IDLE, SEQ_DONE, SEQ_ERR});
      done <= n_st == SEQ_DONE;
      err <= n_st == SEQ_ERR || (err && !acc);
      err_ch <= n_st == SEQ_ERR ? 2'(n_ch) : err_ch;
    end
  end
endmodule
